dmem_bist: RTL and testbench

- Built-in self-test initiator for the single-port data memory `dmem`: synchronous write, combinational read, 64 x 32-bit words.
- Drives the memory's write-enable, address and write-data pins, and checks the read data against a March C- sequence.
- Reports pass/fail and the first failing address and data.
- Sits between the testbench (or the power-on sequencer) and `dmem`; replaces hand-written memory checks in benches.

---
 rtl/dmem_bist_pkg.sv | 56 +++++
 rtl/dmem_bist_march_addr_gen.sv | 36 +++
 rtl/dmem_bist.sv | 117 +++++++++++
 tb/tb_dmem_bist.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bist_pkg.sv
// Shared types and March C- element tables for the dmem BIST initiator.
package dmem_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } elem_t;

    // One bit per element, bit i belongs to element Ei.
    localparam logic [5:0] ELEM_DESC   = 6'b111000; // descending address order
    localparam logic [5:0] ELEM_RD     = 6'b111110; // element reads and compares
    localparam logic [5:0] ELEM_WR     = 6'b011111; // element writes
    localparam logic [5:0] ELEM_EXP_P1 = 6'b010100; // expected read data is all ones
    localparam logic [5:0] ELEM_WR_P1  = 6'b001010; // written data is all ones

    function automatic logic elem_desc(input elem_t e);
        return ELEM_DESC[e];
    endfunction

    function automatic logic elem_rd(input elem_t e);
        return ELEM_RD[e];
    endfunction

    function automatic logic elem_wr(input elem_t e);
        return ELEM_WR[e];
    endfunction

    function automatic logic elem_exp_p1(input elem_t e);
        return ELEM_EXP_P1[e];
    endfunction

    function automatic logic elem_wr_p1(input elem_t e);
        return ELEM_WR_P1[e];
    endfunction

    function automatic elem_t elem_next(input elem_t e);
        case (e)
            E0:      return E1;
            E1:      return E2;
            E2:      return E3;
            E3:      return E4;
            default: return E5;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bist_march_addr_gen.sv
// Up/down march address counter. Direction is latched on load so that the
// terminal flag depends only on registered state.
module march_addr_gen #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              dir,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam logic [ADDR_W-1:0] TOP = '1;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr_q;
    logic              dir_q;

    // Load to the element's start address, otherwise advance on step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            dir_q  <= 1'b0;
        end else if (load) begin
            addr_q <= dir ? TOP : '0;
            dir_q  <= dir;
        end else if (step) begin
            addr_q <= dir_q ? (addr_q - ONE) : (addr_q + ONE);
        end
    end

    assign addr = addr_q;
    assign last = dir_q ? (addr_q == '0) : (addr_q == TOP);

endmodule

// File: rtl/dmem_bist.sv
// March C- BIST initiator for the single-port dmem (sync write, comb read).
module dmem_bist
    import dmem_bist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);
    state_t            state_q, state_d;
    elem_t             elem_q, elem_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    logic              ag_load, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr;
    logic              run;
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;

    march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .load  (ag_load),
        .dir   (elem_desc(elem_d)),
        .step  (ag_step),
        .addr  (ag_addr),
        .last  (ag_last)
    );

    assign run      = (state_q == RUN);
    assign exp_data = {DATA_W{elem_exp_p1(elem_q)}};
    assign mismatch = run && elem_rd(elem_q) && (mem_rd != exp_data);

    // Memory pins come only from state/element/address registers.
    assign mem_we  = run && elem_wr(elem_q);
    assign mem_adr = run ? ag_addr : '0;
    assign mem_wd  = mem_we ? {DATA_W{elem_wr_p1(elem_q)}} : '0;

    assign busy      = run;
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

    // State, element and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            elem_q      <= E0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    // Next-state: launch, element sequencing, first-mismatch capture.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        ag_load     = 1'b0;
        ag_step     = 1'b0;
        case (state_q)
            RUN: begin
                if (mismatch) begin
                    // The write of this cycle still lands; mem_we is registered-derived.
                    state_d     = DONE;
                    pass_d      = 1'b0;
                    fail_addr_d = ag_addr;
                    fail_data_d = mem_rd;
                end else if (ag_last) begin
                    if (elem_q == E5) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        elem_d  = elem_next(elem_q);
                        ag_load = 1'b1;
                    end
                end else begin
                    ag_step = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d     = RUN;
                    elem_d      = E0;
                    ag_load     = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_bist.sv
// Self-checking bench: behavioural dmem with one injectable stuck-at fault,
// checked against a plain March C- reference run over an array.
module tb_dmem_bist;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass, mem_we;
    logic [AW-1:0] fail_addr, mem_adr;
    logic [DW-1:0] fail_data, mem_wd, mem_rd;

    logic [DW-1:0] mem [DEPTH];

    // fault: ftype 0 none, 1 stuck-at-0, 2 stuck-at-1 on bit fb of address fa
    int f_type = 0, f_addr = 0, f_bit = 0;

    int errors = 0, checks = 0;
    int we_cnt = 0, we_bad = 0;

    always #5 clk = ~clk;

    dmem_bist dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] m;
        m = '0;
        m[f_bit] = 1'b1;
        if (a != f_addr) return v;
        if (f_type == 1) return v & ~m;
        if (f_type == 2) return v | m;
        return v;
    endfunction

    always_comb mem_rd = faulty(mem[mem_adr], int'(mem_adr));

    always @(posedge clk) if (mem_we) mem[mem_adr] <= mem_wd;

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            if (!busy) we_bad <= we_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: run the six March C- elements over a plain array.
    task automatic mdl_run(output int edges, output bit ok, output int faddr,
                           output logic [DW-1:0] fdata, output int nwr);
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] rv, ev;
        int k, a;
        k = 0; nwr = 0; ok = 1'b1; faddr = 0; fdata = '0; edges = 6 * DEPTH;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = (e >= 3) ? DEPTH - 1 - i : i;
                rv = faulty(m[a], a);
                ev = (e == 2 || e == 4) ? '1 : '0;
                if (e != 5) begin
                    m[a] = (e == 1 || e == 3) ? '1 : '0;
                    nwr++;
                end
                if (e != 0 && rv != ev) begin
                    ok = 1'b0; faddr = a; fdata = rv; edges = k + 1;
                    return;
                end
                k++;
            end
        end
    endtask

    // Called at T0+1: count edges to done, checking busy all the way.
    task automatic wait_done(input string tag, input bit pulse_mid, input int hold_at, output int n);
        int bbad;
        bbad = busy ? 0 : 1;
        n = 0;
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
            if (pulse_mid && n == 50) start = 1'b1;
            if (pulse_mid && n == 51) start = 1'b0;
            if (n == hold_at) start = 1'b1;
            if (!done && !busy) bbad++;
        end
        chk({tag, "_busy"}, 64'(bbad), 64'd0);
    endtask

    task automatic run_case(input string tag, input int ft, input int fa, input int fb,
                            input bit pulse_mid, input bit hold);
        int edges, faddr, nwr, n, nz;
        bit ok;
        logic [DW-1:0] fdata;
        f_type = ft; f_addr = fa; f_bit = fb;
        mdl_run(edges, ok, faddr, fdata, nwr);
        @(negedge clk);
        we_cnt = 0; we_bad = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(tag, pulse_mid, hold ? edges - 1 : -1, n);
        chk({tag, "_edges"}, 64'(n), 64'(edges));
        chk({tag, "_pass"}, 64'(pass), 64'(ok));
        chk({tag, "_faddr"}, 64'(fail_addr), 64'(faddr));
        chk({tag, "_fdata"}, 64'(fail_data), 64'(fdata));
        chk({tag, "_we_cnt"}, 64'(we_cnt), 64'(nwr));
        chk({tag, "_we_bad"}, 64'(we_bad), 64'd0);
        if (ok) begin
            nz = 0;
            for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) nz++;
            chk({tag, "_mem_zero"}, 64'(nz), 64'd0);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {59'd0, busy, done, pass, mem_we, 1'b0}, 64'd0);
        chk("reset_data", {20'd0, fail_addr, fail_data, mem_adr}, 64'd0);
        chk("reset_wd", 64'(mem_wd), 64'd0);
        @(negedge clk) reset = 1'b0;

        // healthy memory: done/pass after exactly 384 edges, 320 writes
        run_case("healthy", 0, 0, 0, 1'b0, 1'b0);
        chk("healthy_done", 64'(done), 64'd1);

        // bit 3 stuck-at-1 at address 5: fails in E1, RUN cycle 69
        run_case("sa1_a5b3", 2, 5, 3, 1'b0, 1'b0);
        chk("sa1_spec_addr", 64'(fail_addr), 64'd5);
        chk("sa1_spec_data", 64'(fail_data), 64'h8);
        chk("sa1_spec_flags", {62'd0, done, pass}, 64'b10);

        // bit 31 stuck-at-0 at address 63: fails in E2, RUN cycle 191
        run_case("sa0_a63b31", 1, 63, 31, 1'b0, 1'b0);
        chk("sa0_spec_addr", 64'(fail_addr), 64'd63);
        chk("sa0_spec_data", 64'(fail_data), 64'h7FFFFFFF);

        // start pulse during RUN is ignored
        run_case("pulse_mid", 0, 0, 0, 1'b1, 1'b0);

        // start held through DONE restarts the edge after done rises
        run_case("hold", 2, 5, 3, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("hold_restart_ctl", {61'd0, busy, done, pass}, 64'b100);
        chk("hold_restart_res", {26'd0, fail_addr, fail_data}, 64'd0);
        start = 1'b0;
        we_cnt = 0;
        wait_done("hold2", 1'b0, -1, n);
        chk("hold2_edges", 64'(n), 64'd70);
        chk("hold2_faddr", 64'(fail_addr), 64'd5);

        // reset during RUN cycle 100 aborts asynchronously
        @(negedge clk);
        f_type = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ctl", {60'd0, busy, done, pass, mem_we}, 64'd0);
        chk("midrst_data", {20'd0, fail_addr, fail_data, mem_adr}, 64'd0);
        chk("midrst_wd", 64'(mem_wd), 64'd0);
        @(negedge clk) reset = 1'b0;
        run_case("after_rst", 0, 0, 0, 1'b0, 1'b0);

        // randomized single stuck-at faults
        for (int r = 0; r < 10; r++) begin
            run_case($sformatf("rnd%0d", r), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DW - 1)),
                     1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
